br_redirect_ctl: RTL and testbench

//  Consumer end of the EX integer-branch resolution interface. Takes per-cycle branch results
//  (resvld/mispred/target/age), keeps the oldest outstanding mispredict, issues a one-cycle

---
 rtl/br_redirect_ctl.sv | 167 ++++++++++++++++
 tb/tb_br_redirect_ctl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_redirect_ctl.sv
// Branch redirect controller: keeps the oldest outstanding mispredict from EX, pulses a
// backend flush, drains, then holds a fetch redirect until fetch accepts it.
//
// state      | meaning
// -----------|-----------------------------------------------------------------
// S_IDLE     | no mispredict outstanding, fetch free-running
// S_FLUSH    | one-cycle flush pulse for cur_age
// S_DRAIN    | down-counting drain interval before the redirect is offered
// S_REDIRECT | redirect_pc held until redirect_rdy; newer-older events go to pending
module br_redirect_ctl #(
    parameter int ROB_AW       = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int PA_W         = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resvld_ex0,
    input  logic              mispred_ex0,
    input  logic [PA_W-1:0]   br_tgt_ex0,
    input  logic [ROB_AW:0]   br_age_ex0,
    output logic              flush_vld,
    output logic [ROB_AW:0]   flush_age,
    output logic              redirect_vld,
    output logic [PA_W-1:0]   redirect_pc,
    input  logic              redirect_rdy,
    output logic              fetch_stall,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_DRAIN    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PA_W-1:0]    cur_tgt, pnd_tgt;
    logic [ROB_AW:0]    cur_age, pnd_age;
    logic               pnd_vld;
    logic [DW-1:0]      drn_cnt;
    logic [CNT_W-1:0]   cnt;

    logic               ev, hs, ev_older_cur, ev_older_ref;
    logic               cap_new, cap_pnd, wr_pnd, clr_pnd, accept, load_drn;
    logic [ROB_AW:0]    ref_age;

    // Ages carry a wrap bit above the ROB index; a flipped wrap bit reverses the index order.
    function automatic logic older(input logic [ROB_AW:0] a, input logic [ROB_AW:0] b);
        if (a[ROB_AW] == b[ROB_AW])
            return a[ROB_AW-1:0] < b[ROB_AW-1:0];
        else
            return a[ROB_AW-1:0] > b[ROB_AW-1:0];
    endfunction

    assign ev           = resvld_ex0 & mispred_ex0;
    assign hs           = (state == S_REDIRECT) & redirect_rdy;
    assign ref_age      = pnd_vld ? pnd_age : cur_age;
    assign ev_older_cur = ev & older(br_age_ex0, cur_age);
    assign ev_older_ref = ev & older(br_age_ex0, ref_age);

    always_comb begin
        state_nxt = state;
        cap_new   = 1'b0;
        cap_pnd   = 1'b0;
        wr_pnd    = 1'b0;
        clr_pnd   = 1'b0;
        accept    = 1'b0;
        load_drn  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ev) begin
                    cap_new   = 1'b1;
                    accept    = 1'b1;
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (ev_older_cur) begin
                    cap_new   = 1'b1;
                    accept    = 1'b1;
                    state_nxt = S_FLUSH;
                end else begin
                    load_drn  = 1'b1;
                    state_nxt = (DRAIN_CYCLES > 0) ? S_DRAIN : S_REDIRECT;
                end
            end
            S_DRAIN: begin
                if (ev_older_cur) begin
                    cap_new   = 1'b1;
                    accept    = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (drn_cnt == '0) begin
                    state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                // A fresh older event beats whatever is already pending.
                if (hs) begin
                    if (ev_older_ref) begin
                        cap_new   = 1'b1;
                        accept    = 1'b1;
                        clr_pnd   = 1'b1;
                        state_nxt = S_FLUSH;
                    end else if (pnd_vld) begin
                        cap_pnd   = 1'b1;
                        clr_pnd   = 1'b1;
                        state_nxt = S_FLUSH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (ev_older_ref) begin
                    wr_pnd = 1'b1;
                    accept = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_tgt <= '0;
            cur_age <= '0;
            pnd_vld <= 1'b0;
            pnd_tgt <= '0;
            pnd_age <= '0;
            drn_cnt <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (cap_new) begin
                cur_tgt <= br_tgt_ex0;
                cur_age <= br_age_ex0;
            end else if (cap_pnd) begin
                cur_tgt <= pnd_tgt;
                cur_age <= pnd_age;
            end
            if (clr_pnd) begin
                pnd_vld <= 1'b0;
            end else if (wr_pnd) begin
                pnd_vld <= 1'b1;
                pnd_tgt <= br_tgt_ex0;
                pnd_age <= br_age_ex0;
            end
            if (load_drn)
                drn_cnt <= DRN_LOAD;
            else if (state == S_DRAIN && drn_cnt != '0)
                drn_cnt <= drn_cnt - 1'b1;
            if (accept && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    assign flush_vld    = (state == S_FLUSH);
    assign flush_age    = flush_vld ? cur_age : '0;
    assign redirect_vld = (state == S_REDIRECT);
    assign redirect_pc  = redirect_vld ? cur_tgt : '0;
    assign fetch_stall  = (state != S_IDLE);
    assign mispred_cnt  = cnt;

endmodule

// File: tb/tb_br_redirect_ctl.sv
// Bench for br_redirect_ctl: directed scenarios plus random traffic, all compared against a
// timeline model (flush cycle number, redirect window) that tracks the oldest mispredict.
module tb_br_redirect_ctl;

    localparam int ROB_AW = 5;
    localparam int AW     = ROB_AW + 1;
    localparam int DRAIN  = 2;
    localparam int CNT_W  = 16;
    localparam int PA_W   = 40;
    localparam int VW     = 1 + AW + 1 + PA_W + 1 + CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              resvld_ex0, mispred_ex0, redirect_rdy;
    logic [PA_W-1:0]   br_tgt_ex0;
    logic [AW-1:0]     br_age_ex0;
    logic              flush_vld, redirect_vld, fetch_stall;
    logic [AW-1:0]     flush_age;
    logic [PA_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  mispred_cnt;

    br_redirect_ctl #(.ROB_AW(ROB_AW), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W), .PA_W(PA_W)) dut (
        .clk(clk), .reset(reset),
        .resvld_ex0(resvld_ex0), .mispred_ex0(mispred_ex0),
        .br_tgt_ex0(br_tgt_ex0), .br_age_ex0(br_age_ex0),
        .flush_vld(flush_vld), .flush_age(flush_age),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .redirect_rdy(redirect_rdy),
        .fetch_stall(fetch_stall), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Timeline model: a flush is issued at m_flush_cyc; redirect is offered from
    // m_flush_cyc+1+DRAIN until accepted.
    int              cyc = 0;
    bit              m_busy;
    int              m_flush_cyc;
    logic [AW-1:0]   m_cur_age, m_pnd_age;
    logic [PA_W-1:0] m_cur_tgt, m_pnd_tgt;
    bit              m_pnd_vld;
    int              m_cnt;

    wire [VW-1:0] act_vec = {flush_vld, flush_age, redirect_vld, redirect_pc, fetch_stall, mispred_cnt};

    // a is older than b when b lies 1..2^ROB_AW-1 steps ahead of a around the age circle.
    function automatic bit m_older(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] d;
        d = b - a;
        return (d != 0) && (int'(d) < (1 << ROB_AW));
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        bit fl, rd;
        fl = m_busy && (cyc == m_flush_cyc);
        rd = m_busy && (cyc >= m_flush_cyc + 1 + DRAIN);
        return {fl, fl ? m_cur_age : {AW{1'b0}}, rd, rd ? m_cur_tgt : {PA_W{1'b0}},
                logic'(m_busy), CNT_W'(m_cnt)};
    endfunction

    task automatic model_step(input bit rst, input bit ev, input logic [AW-1:0] a,
                              input logic [PA_W-1:0] t, input bit rdy);
        bit in_red, ev_old;
        if (rst) begin
            m_busy = 0; m_pnd_vld = 0; m_cnt = 0; m_flush_cyc = -100;
            m_cur_age = '0; m_cur_tgt = '0;
            return;
        end
        in_red = m_busy && (cyc >= m_flush_cyc + 1 + DRAIN);
        if (!m_busy) begin
            if (ev) begin
                m_busy = 1; m_cur_age = a; m_cur_tgt = t; m_flush_cyc = cyc + 1; m_cnt++;
            end
        end else if (!in_red) begin
            if (ev && m_older(a, m_cur_age)) begin
                m_cur_age = a; m_cur_tgt = t; m_flush_cyc = cyc + 1; m_cnt++;
            end
        end else begin
            ev_old = ev && m_older(a, m_pnd_vld ? m_pnd_age : m_cur_age);
            if (ev_old) m_cnt++;
            if (rdy) begin
                if (ev_old) begin
                    m_cur_age = a; m_cur_tgt = t; m_flush_cyc = cyc + 1; m_pnd_vld = 0;
                end else if (m_pnd_vld) begin
                    m_cur_age = m_pnd_age; m_cur_tgt = m_pnd_tgt; m_flush_cyc = cyc + 1;
                    m_pnd_vld = 0;
                end else begin
                    m_busy = 0;
                end
            end else if (ev_old) begin
                m_pnd_vld = 1; m_pnd_age = a; m_pnd_tgt = t;
            end
        end
        if (m_cnt > (1 << CNT_W) - 1) m_cnt = (1 << CNT_W) - 1;
    endtask

    task automatic run_cycle(input bit rst, input bit vld, input bit mis,
                             input logic [AW-1:0] a, input logic [PA_W-1:0] t, input bit rdy);
        reset = rst; resvld_ex0 = vld; mispred_ex0 = mis;
        br_age_ex0 = a; br_tgt_ex0 = t; redirect_rdy = rdy;
        @(posedge clk);
        model_step(rst, vld & mis, a, t, rdy);
        cyc++;
        #1;
    endtask

    // Per-scenario observations, indexed by relative output cycle.
    int              rec_first_red, rec_red_cnt, rec_last_flush;
    logic [AW-1:0]   rec_last_flush_age;
    logic [PA_W-1:0] rec_first_pc, rec_last_pc;
    logic            rec_stall [0:63];
    logic            rec_busy_out [0:63];
    logic [PA_W-1:0] rec_pc [0:63];

    task automatic run_scn(input string name, input int len,
                           input int r1, input logic [AW-1:0] a1, input logic [PA_W-1:0] t1,
                           input int r2, input logic [AW-1:0] a2, input logic [PA_W-1:0] t2,
                           input int rdy_r, input int rst_r);
        logic [VW-1:0] e;
        run_cycle(1, 0, 0, '0, '0, 0);
        run_cycle(0, 0, 0, '0, '0, 0);
        rec_first_red = -1; rec_red_cnt = 0; rec_last_flush = -1;
        rec_last_flush_age = '0; rec_first_pc = '0; rec_last_pc = '0;
        for (int r = 0; r < len; r++) begin
            if (r == r1)      run_cycle(r == rst_r, 1, 1, a1, t1, r >= rdy_r);
            else if (r == r2) run_cycle(r == rst_r, 1, 1, a2, t2, r >= rdy_r);
            else              run_cycle(r == rst_r, r[0], 0, 6'h3f, 40'hdead, r >= rdy_r);
            e = exp_vec();
            checks++;
            if (act_vec !== e) begin
                errors++;
                $display("FAIL %s rel_cyc=%0d outputs got=%h exp=%h", name, r + 1, act_vec, e);
            end
            rec_stall[r+1]    = fetch_stall;
            rec_busy_out[r+1] = flush_vld | redirect_vld | fetch_stall | (|mispred_cnt);
            rec_pc[r+1]       = redirect_pc;
            if (flush_vld) begin rec_last_flush = r + 1; rec_last_flush_age = flush_age; end
            if (redirect_vld) begin
                rec_red_cnt++;
                rec_last_pc = redirect_pc;
                if (rec_first_red < 0) begin rec_first_red = r + 1; rec_first_pc = redirect_pc; end
            end
        end
    endtask

    task automatic test_reset();
        run_cycle(1, 1, 1, 6'h01, 40'h1234, 1);
        checks++;
        if (act_vec !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%h exp=0", act_vec);
        end
    endtask

    task automatic test_base();
        run_scn("base", 10, 0, 6'h03, 40'h1000, -1, '0, '0, 0, -1);
        checks++;
        if (rec_last_flush !== 1 || rec_last_flush_age !== 6'h03) begin
            errors++;
            $display("FAIL base_flush got cyc=%0d age=%h exp cyc=1 age=03", rec_last_flush, rec_last_flush_age);
        end
        checks++;
        if (rec_first_red !== 4 || rec_first_pc !== 40'h1000 || rec_red_cnt !== 1) begin
            errors++;
            $display("FAIL base_redirect got cyc=%0d pc=%h n=%0d exp cyc=4 pc=1000 n=1",
                     rec_first_red, rec_first_pc, rec_red_cnt);
        end
        checks++;
        if (rec_stall[5] !== 1'b0 || mispred_cnt !== 16'd1) begin
            errors++;
            $display("FAIL base_idle got stall=%b cnt=%0d exp stall=0 cnt=1", rec_stall[5], mispred_cnt);
        end
    endtask

    task automatic test_drop_younger();
        run_scn("drop", 10, 0, 6'h03, 40'h1000, 2, 6'h05, 40'h2000, 0, -1);
        checks++;
        if (rec_first_red !== 4 || rec_last_pc !== 40'h1000 || mispred_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop got cyc=%0d pc=%h cnt=%0d exp cyc=4 pc=1000 cnt=1",
                     rec_first_red, rec_last_pc, mispred_cnt);
        end
    endtask

    task automatic test_older_replace();
        run_scn("older", 12, 0, 6'h03, 40'h1000, 2, 6'h01, 40'h2000, 0, -1);
        checks++;
        if (rec_last_flush !== 3 || rec_last_flush_age !== 6'h01) begin
            errors++;
            $display("FAIL older_flush got cyc=%0d age=%h exp cyc=3 age=01", rec_last_flush, rec_last_flush_age);
        end
        checks++;
        if (rec_first_red !== 6 || rec_first_pc !== 40'h2000 || mispred_cnt !== 16'd2) begin
            errors++;
            $display("FAIL older_redirect got cyc=%0d pc=%h cnt=%0d exp cyc=6 pc=2000 cnt=2",
                     rec_first_red, rec_first_pc, mispred_cnt);
        end
    endtask

    task automatic test_wrap();
        run_scn("wrap", 12, 0, 6'b1_00010, 40'h1000, 2, 6'b0_11110, 40'h3000, 0, -1);
        checks++;
        if (rec_last_flush_age !== 6'b0_11110 || rec_first_pc !== 40'h3000) begin
            errors++;
            $display("FAIL wrap got age=%b pc=%h exp age=011110 pc=3000", rec_last_flush_age, rec_first_pc);
        end
    endtask

    task automatic test_redirect_hold();
        run_scn("hold", 16, 0, 6'h03, 40'h1000, 5, 6'h01, 40'h4000, 7, -1);
        checks++;
        if (rec_first_red !== 4 || rec_pc[6] !== 40'h1000 || rec_pc[7] !== 40'h1000) begin
            errors++;
            $display("FAIL hold_pc got cyc=%0d pc6=%h pc7=%h exp cyc=4 pc=1000",
                     rec_first_red, rec_pc[6], rec_pc[7]);
        end
        checks++;
        if (rec_last_flush !== 8 || rec_last_flush_age !== 6'h01 || rec_last_pc !== 40'h4000 ||
            mispred_cnt !== 16'd2) begin
            errors++;
            $display("FAIL hold_reflush got cyc=%0d age=%h pc=%h cnt=%0d exp cyc=8 age=01 pc=4000 cnt=2",
                     rec_last_flush, rec_last_flush_age, rec_last_pc, mispred_cnt);
        end
    endtask

    task automatic test_reset_mid();
        run_scn("rst_mid", 10, 0, 6'h03, 40'h1000, -1, '0, '0, 0, 2);
        checks++;
        if (rec_busy_out[3] !== 1'b0 || rec_red_cnt !== 0) begin
            errors++;
            $display("FAIL rst_mid got active=%b redirects=%0d exp active=0 redirects=0",
                     rec_busy_out[3], rec_red_cnt);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        logic [AW-1:0] base;
        run_cycle(1, 0, 0, '0, '0, 0);
        base = '0;
        for (int i = 0; i < 4000; i++) begin
            // Ages cluster near a slowly advancing head so older/younger both occur, with wrap.
            if ($urandom_range(0, 7) == 0) base = base + 1'b1;
            run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      base + AW'($urandom_range(0, 12)), {8'h0, 32'($urandom)},
                      $urandom_range(0, 2) != 0);
            e = exp_vec();
            checks++;
            if (act_vec !== e) begin
                errors++;
                $display("FAIL random cyc=%0d outputs got=%h exp=%h", i, act_vec, e);
            end
        end
    endtask

    initial begin
        reset = 1; resvld_ex0 = 0; mispred_ex0 = 0; redirect_rdy = 0;
        br_age_ex0 = '0; br_tgt_ex0 = '0;
        m_busy = 0; m_pnd_vld = 0; m_cnt = 0; m_flush_cyc = -100;
        m_cur_age = '0; m_cur_tgt = '0; m_pnd_age = '0; m_pnd_tgt = '0;
        #1;
        test_reset();
        test_base();
        test_drop_younger();
        test_older_replace();
        test_wrap();
        test_redirect_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
